timer_controller: RTL
=====================

Name: timer_controller

Overview:
Pattern-triggered delay timer controller. It watches a serial `data` stream for the start pattern 1101, then shifts in a DELAY_W-bit delay value MSB-first. It then counts (delay+1)*SCALE clock cycles and raises `done`, holding it until the consumer acknowledges with `ack`. It sequences the serial detect, shift, count and notify datapath as a single FSM plus a shift counter, a cycle prescaler and a down-counter.

Parameters:
DELAY_W, 4, width of the shifted-in delay value and of the `count` output
SCALE, 1000, cycles per delay unit; legal range >= 1; prescaler width = max(1, clog2(SCALE))

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
data  input  1  serial input, sampled every rising edge
ack  input  1  consumer acknowledge; only meaningful in WAIT_ACK
shifting  output  1  high while in SHIFT
counting  output  1  high while in COUNT
done  output  1  high while in WAIT_ACK
count  output  DELAY_W  remaining whole delay units during COUNT; 0 in all other states
state_out  output  3  current FSM state encoding, for debug

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is synchronous and active-high. Reset sets the state to S0 and clears the shift counter, prescaler, delay register and count register. While reset is asserted, and on the first cycle after it, all outputs are 0.
- State encoding: S0=0, S1=1, S2=2, S3=3, SHIFT=4, COUNT=5, WAIT_ACK=6. Code 7 is illegal and returns to S0 on the next edge.
- Pattern search transitions (overlapping detection):
  - S0: data=1 -> S1, else S0
  - S1: data=1 -> S2, else S0
  - S2: data=1 -> S2, data=0 -> S3
  - S3: data=1 -> SHIFT, else S0
- SHIFT:
  - Lasts exactly DELAY_W cycles.
  - Each edge: delay <= {delay[DELAY_W-2:0], data}; shift counter increments.
  - On the edge that captures the last bit: load the count register with the final delay value (including that bit), clear the prescaler, go to COUNT.
  - `data` is not pattern-checked in this state.
- COUNT:
  - The prescaler increments every cycle.
  - When prescaler == SCALE-1: prescaler <= 0. Then, if count == 0, go to WAIT_ACK; otherwise count <= count-1.
  - Total COUNT duration is exactly (delay+1)*SCALE cycles.
  - `count` shows delay for the first SCALE cycles, decrements by 1 every SCALE cycles, and shows 0 for the final SCALE cycles.
  - delay=0 gives SCALE cycles; delay=all-ones gives 2^DELAY_W * SCALE cycles. There is no wrap or overflow.
  - `data` and `ack` are ignored.
- WAIT_ACK:
  - `done`=1.
  - ack=1 sampled -> S0 (pattern progress cleared; bits seen during WAIT_ACK never count toward a new pattern).
  - ack=0 -> stay. There is no timeout.
- Ack handling: ack asserted outside WAIT_ACK is ignored and is not remembered.
- Output timing: all outputs are decoded from registered state only; there is no combinational path from `data` or `ack` to any output.
- Latency: the final pattern bit is sampled at edge t. `shifting` is 1 for cycles t+1..t+DELAY_W. `counting` runs from t+DELAY_W+1. `done` rises (delay+1)*SCALE cycles after that.
- Reset mid-operation: reset in any state returns to S0 on that edge and abandons the delay, count and done without completion.
- Simultaneous events: reset dominates ack and data. In WAIT_ACK, an ack on the same edge as data=1 goes to S0; that data bit is not used as pattern progress.

Test Plan (bench uses SCALE=4, DELAY_W=4):
1. Basic run: after reset, data 1,1,0,1 then 0,1,0,1 (delay=5) -> `shifting` high 4 cycles; `counting` high exactly 24 cycles; `count` = 5,5,5,5,4,...,0,0,0,0; then `done`=1 held 10 cycles with ack=0; ack=1 for 1 cycle -> `done`=0 next cycle, state_out=0.
2. Overlap/false starts: data 1,1,1,1,0,1 then delay 0000 -> detection on the 6th bit; `counting` exactly 4 cycles with count=0; data sequence 1,1,0,0,1,1,0,1 detected only at the final 1.
3. Extremes: delay=1111 -> `counting` exactly 64 cycles, count starts at 15 and reaches 0 without wrap. Delay=0000 -> exactly 4 cycles.
4. Ignored inputs: pattern 1101 driven during SHIFT payload and during COUNT causes no restart; ack pulses during COUNT have no effect (`done` still rises on time and waits for a later ack); data stream 1101 during WAIT_ACK followed by ack -> returns to S0, no immediate re-trigger.
5. Reset mid-operation: assert reset for 1 cycle during SHIFT, during COUNT (count=3) and during WAIT_ACK -> all outputs 0 and state_out=0 the next cycle; a fresh 1101 + delay then runs with full-length timing.
6. Back-to-back: ack on the same edge as data=1 in WAIT_ACK, then 1,0,1,0,0,1,1 -> state_out goes 0, then S1 from the second 1; detection completes on the expected bit and counting timing is exact.

Source files
------------

// File: rtl/timer_controller.sv
// Pattern-triggered delay timer: finds 1101 on a serial line, shifts in a delay,
// waits (delay+1)*SCALE cycles, then holds done until acknowledged.
module timer_controller #(
    parameter int DELAY_W = 4,
    parameter int SCALE   = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data,
    input  logic               ack,
    output logic               shifting,
    output logic               counting,
    output logic               done,
    output logic [DELAY_W-1:0] count,
    output logic [2:0]         state_out
);

    localparam int PRE_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int SHC_W = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCALE - 1);
    localparam logic [SHC_W-1:0] SHC_LAST = SHC_W'(DELAY_W - 1);

    typedef enum logic [2:0] {
        S0       = 3'd0,
        S1       = 3'd1,
        S2       = 3'd2,
        S3       = 3'd3,
        SHIFT    = 3'd4,
        COUNT    = 3'd5,
        WAIT_ACK = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SHC_W-1:0]   r_shift_cnt;
    logic [PRE_W-1:0]   r_prescale;
    logic [DELAY_W-1:0] r_delay;
    logic [DELAY_W-1:0] r_count;

    logic               w_last_bit;
    logic               w_unit_end;
    logic               w_count_zero;
    logic [DELAY_W-1:0] w_delay_next;

    assign w_last_bit   = (r_shift_cnt == SHC_LAST);
    assign w_unit_end   = (r_prescale == PRE_LAST);
    assign w_count_zero = (r_count == '0);
    assign w_delay_next = DELAY_W'({r_delay, data});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S0;
        case (r_state)
            S0:       w_state_next = data ? S1 : S0;
            S1:       w_state_next = data ? S2 : S0;
            S2:       w_state_next = data ? S2 : S3;
            S3:       w_state_next = data ? SHIFT : S0;
            SHIFT:    w_state_next = w_last_bit ? COUNT : SHIFT;
            COUNT:    w_state_next = (w_unit_end && w_count_zero) ? WAIT_ACK : COUNT;
            WAIT_ACK: w_state_next = ack ? S0 : WAIT_ACK;
            default:  w_state_next = S0;
        endcase
    end

    // Shift counter restarts outside SHIFT so every payload begins at bit zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift_cnt <= '0;
            r_prescale  <= '0;
            r_delay     <= '0;
            r_count     <= '0;
        end else if (r_state == SHIFT) begin
            r_delay <= w_delay_next;
            if (w_last_bit) begin
                r_shift_cnt <= '0;
                r_count     <= w_delay_next;
                r_prescale  <= '0;
            end else begin
                r_shift_cnt <= r_shift_cnt + SHC_W'(1);
            end
        end else if (r_state == COUNT) begin
            r_shift_cnt <= '0;
            if (w_unit_end) begin
                r_prescale <= '0;
                if (!w_count_zero) begin
                    r_count <= r_count - DELAY_W'(1);
                end
            end else begin
                r_prescale <= r_prescale + PRE_W'(1);
            end
        end else begin
            r_shift_cnt <= '0;
        end
    end

    always_comb begin
        shifting  = (r_state == SHIFT);
        counting  = (r_state == COUNT);
        done      = (r_state == WAIT_ACK);
        count     = (r_state == COUNT) ? r_count : '0;
        state_out = r_state;
    end

endmodule
